// File: rtl/eth_pkg.sv
// Shared Ethernet receive constants, route/state encodings and the route decision.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
  localparam logic [7:0]  IP_PROTO_ICMP = 8'd1;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int IDX_W = 6;
  localparam logic [IDX_W-1:0] IDX_SFD      = 6'd7;
  localparam logic [IDX_W-1:0] IDX_ETYPE_HI = 6'd20;
  localparam logic [IDX_W-1:0] IDX_ETYPE_LO = 6'd21;
  localparam logic [IDX_W-1:0] IDX_VER      = 6'd22;
  localparam logic [IDX_W-1:0] IDX_PROTO    = 6'd31;
  localparam logic [IDX_W-1:0] IDX_MAX      = 6'd32;

  typedef enum logic [1:0] {NONE, ARP, UDP, ICMP} route_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_HDR, ST_BODY} rx_state_t;

  function automatic route_t decide_route(input logic        bad,
                                          input logic [15:0] etype,
                                          input logic [3:0]  ver,
                                          input logic [7:0]  proto);
    route_t r;
    r = NONE;
    if (!bad) begin
      if (etype == ETH_TYPE_ARP) begin
        r = ARP;
      end else if (etype == ETH_TYPE_IP && ver == 4'd4) begin
        if (proto == IP_PROTO_UDP)       r = UDP;
        else if (proto == IP_PROTO_ICMP) r = ICMP;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_rx_dly_line.sv
// Fixed-depth {dv, data} shift register; a masked clear kills the dv bits of a runt frame in flight.
module eth_rx_dly_line
  import eth_pkg::*;
#(
  parameter int DLY = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_dv,
  input  logic [7:0]     in_data,
  input  logic           clr,
  input  logic [DLY-2:0] clr_mask,
  output logic           last_dv,
  output logic [7:0]     last_data
);

  logic [DLY-1:0] dv_reg;
  logic [DLY-1:0] dv_next;
  logic [7:0]     data_reg [DLY];

  assign dv_next[0] = in_dv;

  // clr_mask[i] marks stage i as holding a byte of the frame being discarded
  generate
    for (genvar gi = 1; gi < DLY; gi++) begin : g_stage
      assign dv_next[gi] = dv_reg[gi-1] & ~(clr & clr_mask[gi-1]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_reg <= '0;
      for (int i = 0; i < DLY; i++) data_reg[i] <= 8'h00;
    end else begin
      dv_reg      <= dv_next;
      data_reg[0] <= in_data;
      for (int i = 1; i < DLY; i++) data_reg[i] <= data_reg[i-1];
    end
  end

  assign last_dv   = dv_reg[DLY-1];
  assign last_data = data_reg[DLY-1];

endmodule

// File: rtl/eth_rx_dispatch.sv
// GMII receive dispatcher: parses preamble/EtherType/IPv4 protocol and steers each whole
// frame, delayed by DLY bytes, to the ARP, UDP or ICMP receiver, or drops it.
module eth_rx_dispatch
  import eth_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DLY   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic             arp_gmii_rx_dv,
  output logic [7:0]       arp_gmii_rxd,
  output logic             udp_gmii_rx_dv,
  output logic [7:0]       udp_gmii_rxd,
  output logic             icmp_gmii_rx_dv,
  output logic [7:0]       icmp_gmii_rxd,
  output logic [CNT_W-1:0] drop_cnt
);

  rx_state_t        state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             bad_reg, bad_next;
  logic [15:0]      etype_reg, etype_next;
  logic [3:0]       ver_reg, ver_next;
  route_t           route_reg, route_next;
  logic [CNT_W-1:0] drop_cnt_reg;
  logic             dv_low_reg;
  logic             accept;
  logic             drop_inc;
  logic             runt_clr;
  logic [7:0]       pre_expect;

  logic             arp_dv_reg, udp_dv_reg, icmp_dv_reg;
  logic [7:0]       arp_rxd_reg, udp_rxd_reg, icmp_rxd_reg;

  logic             last_dv;
  logic [7:0]       last_data;
  logic [DLY-2:0]   clr_mask;

  // Thermometer of bytes received so far: stages 0..idx-1 hold the current frame
  generate
    for (genvar gi = 0; gi < DLY - 1; gi++) begin : g_mask
      assign clr_mask[gi] = (idx_reg > IDX_W'(gi));
    end
  endgenerate

  eth_rx_dly_line #(.DLY(DLY)) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_dv     (accept),
    .in_data   (gmii_rxd),
    .clr       (runt_clr),
    .clr_mask  (clr_mask),
    .last_dv   (last_dv),
    .last_data (last_data)
  );

  assign pre_expect = (idx_reg == IDX_SFD) ? SFD_BYTE : PREAMBLE_BYTE;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    bad_next   = bad_reg;
    etype_next = etype_reg;
    ver_next   = ver_reg;
    route_next = route_reg;
    accept     = 1'b0;
    drop_inc   = 1'b0;
    runt_clr   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        idx_next = '0;
        // Only a true rising edge of dv starts a frame; a frame already running is ignored
        if (gmii_rx_dv && dv_low_reg) begin
          accept     = 1'b1;
          state_next = ST_PRE;
          idx_next   = 6'd1;
          bad_next   = (gmii_rxd != PREAMBLE_BYTE);
        end
      end
      ST_PRE: begin
        if (!gmii_rx_dv) begin
          runt_clr   = 1'b1;
          drop_inc   = 1'b1;
          state_next = ST_IDLE;
          idx_next   = '0;
        end else begin
          accept   = 1'b1;
          idx_next = idx_reg + 6'd1;
          if (gmii_rxd != pre_expect) bad_next = 1'b1;
          if (idx_reg == IDX_SFD) state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!gmii_rx_dv) begin
          runt_clr   = 1'b1;
          drop_inc   = 1'b1;
          state_next = ST_IDLE;
          idx_next   = '0;
        end else begin
          accept   = 1'b1;
          idx_next = idx_reg + 6'd1;
          if (idx_reg == IDX_ETYPE_HI) etype_next[15:8] = gmii_rxd;
          if (idx_reg == IDX_ETYPE_LO) etype_next[7:0]  = gmii_rxd;
          if (idx_reg == IDX_VER)      ver_next         = gmii_rxd[7:4];
          if (idx_reg == IDX_PROTO) begin
            route_next = decide_route(bad_reg, etype_reg, ver_reg, gmii_rxd);
            drop_inc   = (route_next == NONE);
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        accept = gmii_rx_dv;
        if (!gmii_rx_dv) begin
          state_next = ST_IDLE;
          idx_next   = '0;
        end else if (idx_reg < IDX_MAX) begin
          idx_next = idx_reg + 6'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      bad_reg      <= 1'b0;
      etype_reg    <= 16'h0000;
      ver_reg      <= 4'h0;
      route_reg    <= NONE;
      drop_cnt_reg <= '0;
      dv_low_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      bad_reg    <= bad_next;
      etype_reg  <= etype_next;
      ver_reg    <= ver_next;
      route_reg  <= route_next;
      dv_low_reg <= ~gmii_rx_dv;
      if (drop_inc && (drop_cnt_reg != {CNT_W{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arp_dv_reg   <= 1'b0;
      udp_dv_reg   <= 1'b0;
      icmp_dv_reg  <= 1'b0;
      arp_rxd_reg  <= 8'h00;
      udp_rxd_reg  <= 8'h00;
      icmp_rxd_reg <= 8'h00;
    end else begin
      arp_dv_reg   <= last_dv && (route_reg == ARP);
      udp_dv_reg   <= last_dv && (route_reg == UDP);
      icmp_dv_reg  <= last_dv && (route_reg == ICMP);
      arp_rxd_reg  <= (last_dv && (route_reg == ARP))  ? last_data : 8'h00;
      udp_rxd_reg  <= (last_dv && (route_reg == UDP))  ? last_data : 8'h00;
      icmp_rxd_reg <= (last_dv && (route_reg == ICMP)) ? last_data : 8'h00;
    end
  end

  assign arp_gmii_rx_dv  = arp_dv_reg;
  assign arp_gmii_rxd    = arp_rxd_reg;
  assign udp_gmii_rx_dv  = udp_dv_reg;
  assign udp_gmii_rxd    = udp_rxd_reg;
  assign icmp_gmii_rx_dv = icmp_dv_reg;
  assign icmp_gmii_rxd   = icmp_rxd_reg;
  assign drop_cnt        = drop_cnt_reg;

endmodule
